// File: rtl/luna_pkg.sv
// Shared definitions for the CPU control path: FSM state codes, instruction
// field bit positions and jump condition codes.
package luna_pkg;

  localparam logic [2:0] ST_RESET_WAIT = 3'd0;
  localparam logic [2:0] ST_FETCH      = 3'd1;
  localparam logic [2:0] ST_EXEC       = 3'd2;
  localparam logic [2:0] ST_WB         = 3'd3;
  localparam logic [2:0] ST_HALT       = 3'd4;

  localparam int TYPE_BIT   = 15;
  localparam int A_SEL_BIT  = 12;
  localparam int COMP_HI    = 11;
  localparam int COMP_LO    = 6;
  localparam int DEST_A_BIT = 5;
  localparam int DEST_D_BIT = 4;
  localparam int DEST_M_BIT = 3;
  localparam int JUMP_HI    = 2;
  localparam int JUMP_LO    = 0;

  // Bit meaning inside the jump field: lt / eq / gt against zero
  localparam int J_LT_BIT = 2;
  localparam int J_EQ_BIT = 1;
  localparam int J_GT_BIT = 0;

  localparam logic [2:0] JMP_NEVER  = 3'b000;
  localparam logic [2:0] JMP_ALWAYS = 3'b111;

endpackage

// File: rtl/cpu_jump_eval.sv
// Combinational jump decision from the 3-bit jump field and ALU status flags.
module cpu_jump_eval
  import luna_pkg::*;
(
  input  logic [2:0] jump,
  input  logic       zr,
  input  logic       ng,
  output logic       taken
);

  assign taken = (jump[J_LT_BIT] & ng)
               | (jump[J_EQ_BIT] & zr)
               | (jump[J_GT_BIT] & ~zr & ~ng);

endmodule

// File: rtl/cpu_control.sv
// Instruction sequencer: FETCH / EXEC / WB control with PC and jump handling.
// Optional halt-on-jump-to-self is enabled by defining CPU_CONTROL_HALT_EN.
module cpu_control
  import luna_pkg::*;
#(
  parameter int                WIDTH    = 16,
  parameter logic [WIDTH-1:0]  PC_RESET = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] instr_in,
  input  logic             instr_valid,
  output logic             instr_req,
  output logic [WIDTH-1:0] pc_out,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng,
  output logic [5:0]       alu_ctrl,
  output logic             alu_y_sel_m,
  output logic             reg_a_en,
  output logic             reg_d_en,
  output logic             reg_m_en,
  output logic [WIDTH-1:0] data_out,
  output logic             halted
);

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] data_hold;
  logic [WIDTH-1:0] wb_data;
  logic [WIDTH-1:0] pc_inc;
  logic             is_c;
  logic             jump_cond;
  logic             taken;
  logic             in_wb;

  cpu_jump_eval u_jump_eval (
    .jump  (ir[JUMP_HI:JUMP_LO]),
    .zr    (alu_zr),
    .ng    (alu_ng),
    .taken (jump_cond)
  );

  assign is_c    = ir[TYPE_BIT];
  assign taken   = is_c & jump_cond;
  assign pc_inc  = pc + WIDTH'(1);
  assign in_wb   = (state == ST_WB);
  assign wb_data = is_c ? alu_out : ir;

`ifdef CPU_CONTROL_HALT_EN
  logic halt_hit;
  assign halt_hit = taken & (ir[JUMP_HI:JUMP_LO] == JMP_ALWAYS) & (a_in == pc);
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_RESET_WAIT: state_next = ST_FETCH;
      ST_FETCH:      if (instr_valid) state_next = ST_EXEC;
      ST_EXEC:       state_next = ST_WB;
`ifdef CPU_CONTROL_HALT_EN
      ST_WB:         state_next = halt_hit ? ST_HALT : ST_FETCH;
      ST_HALT:       state_next = ST_HALT;
`else
      ST_WB:         state_next = ST_FETCH;
`endif
      default:       state_next = ST_RESET_WAIT;
    endcase
  end

  // PC and the held write data change only at the end of WB; a_in is sampled
  // at that same edge, so a jump always uses the pre-write A value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RESET_WAIT;
      pc        <= PC_RESET;
      ir        <= '0;
      data_hold <= '0;
    end else begin
      state <= state_next;
      if (state == ST_FETCH && instr_valid) ir <= instr_in;
      if (in_wb) begin
        data_hold <= wb_data;
        pc        <= taken ? a_in : pc_inc;
      end
    end
  end

  assign instr_req   = (state == ST_FETCH);
  assign pc_out      = pc;
  assign alu_ctrl    = ir[COMP_HI:COMP_LO];
  assign alu_y_sel_m = ir[A_SEL_BIT];
  assign reg_a_en    = in_wb & (~is_c | ir[DEST_A_BIT]);
  assign reg_d_en    = in_wb & is_c & ir[DEST_D_BIT];
  assign reg_m_en    = in_wb & is_c & ir[DEST_M_BIT];
  assign data_out    = in_wb ? wb_data : data_hold;

`ifdef CPU_CONTROL_HALT_EN
  assign halted = (state == ST_HALT) | (in_wb & halt_hit);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_control.sv
// Randomized self-checking bench for cpu_control against an instruction-level model.
module tb_cpu_control;

  localparam int          WIDTH    = 16;
  localparam logic [15:0] PC_RESET = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_req;
  logic [15:0] pc_out;
  logic [15:0] a_in;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic [5:0]  alu_ctrl;
  logic        alu_y_sel_m;
  logic        reg_a_en;
  logic        reg_d_en;
  logic        reg_m_en;
  logic [15:0] data_out;
  logic        halted;
  logic        any_en;

  int tests_run    = 0;
  int tests_failed = 0;

  cpu_control #(.WIDTH(WIDTH), .PC_RESET(PC_RESET)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_req   (instr_req),
    .pc_out      (pc_out),
    .a_in        (a_in),
    .alu_out     (alu_out),
    .alu_zr      (alu_zr),
    .alu_ng      (alu_ng),
    .alu_ctrl    (alu_ctrl),
    .alu_y_sel_m (alu_y_sel_m),
    .reg_a_en    (reg_a_en),
    .reg_d_en    (reg_d_en),
    .reg_m_en    (reg_m_en),
    .data_out    (data_out),
    .halted      (halted)
  );

  always #5 clk = ~clk;
  assign any_en = reg_a_en | reg_d_en | reg_m_en;

  typedef struct packed {
    logic        a;
    logic        d;
    logic        m;
    logic [15:0] data;
    logic [15:0] pc_next;
    logic        halt;
  } exp_t;

  // Architectural model: one whole instruction at a time, r is the signed ALU result
  function automatic exp_t model(input logic [15:0] pc, input logic [15:0] instr,
                                 input logic signed [15:0] r, input logic [15:0] a);
    exp_t e;
    logic take;
    e.halt = 1'b0;
    if (instr[15] == 1'b0) begin
      e.a = 1'b1; e.d = 1'b0; e.m = 1'b0; e.data = instr; take = 1'b0;
    end else begin
      e.a = instr[5]; e.d = instr[4]; e.m = instr[3]; e.data = r;
      take = (instr[2] && r < 0) || (instr[1] && r == 0) || (instr[0] && r > 0);
`ifdef CPU_CONTROL_HALT_EN
      if (instr[2:0] == 3'b111 && a == pc) e.halt = 1'b1;
`endif
    end
    e.pc_next = take ? a : 16'((int'(pc) + 1) % 65536);
    return e;
  endfunction

  logic [15:0] model_pc;
  logic        stall_ok, start_req, exec_req, exec_en, post_req, post_en;
  logic        wb_halted, post_halted;
  logic [6:0]  exec_ctrl, wb_ctrl;
  logic [2:0]  wb_en;
  logic [15:0] wb_data, wb_pc, post_data, pc_after;

  // Drives one instruction from FETCH (entered at a negedge) and records observations
  task automatic exec_instr(input logic [15:0] instr, input int stall,
                            input logic signed [15:0] r, input logic [15:0] a);
    logic [15:0] pc0;
    alu_out = r; alu_zr = (r == 0); alu_ng = (r < 0); a_in = a;
    instr_valid = 1'b0;
    stall_ok = 1'b1;
    pc0 = pc_out;
    for (int k = 0; k < stall; k++) begin
      if (instr_req !== 1'b1 || any_en !== 1'b0 || pc_out !== pc0) stall_ok = 1'b0;
      @(negedge clk);
    end
    start_req = instr_req;
    instr_in = instr; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0; instr_in = 16'($urandom);
    exec_req = instr_req; exec_en = any_en; exec_ctrl = {alu_y_sel_m, alu_ctrl};
    @(negedge clk);
    wb_en = {reg_a_en, reg_d_en, reg_m_en}; wb_data = data_out;
    wb_ctrl = {alu_y_sel_m, alu_ctrl}; wb_halted = halted; wb_pc = pc_out;
    @(negedge clk);
    post_req = instr_req; post_en = any_en; post_data = data_out;
    pc_after = pc_out; post_halted = halted;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; instr_in = '0; a_in = '0; alu_out = '0;
    alu_zr = 1'b0; alu_ng = 1'b0;
    @(negedge clk); @(negedge clk);
    tests_run++;
    if ({instr_req, any_en, halted, alu_y_sel_m} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_ctrl: req/en/halt/ysel got %b expected 0000",
               {instr_req, any_en, halted, alu_y_sel_m});
    end
    tests_run++;
    if (pc_out !== PC_RESET || data_out !== 16'h0 || alu_ctrl !== 6'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: pc %h data %h ctrl %h expected %h 0000 00",
               pc_out, data_out, alu_ctrl, PC_RESET);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (instr_req !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_fetch: instr_req got %b expected 1", instr_req);
    end
    model_pc = PC_RESET;
  endtask

  task automatic test_a_instr();
    exp_t e;
    e = model(model_pc, 16'h1234, 16'sh0, 16'h0);
    exec_instr(16'h1234, 0, 16'sh7777, 16'h0);
    tests_run++;
    if ({start_req, exec_req, post_req} !== 3'b101) begin
      tests_failed++;
      $display("[TB] FAIL a_latency: req fetch/exec/next got %b expected 101",
               {start_req, exec_req, post_req});
    end
    tests_run++;
    if (wb_en !== {e.a, e.d, e.m} || wb_data !== e.data || post_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL a_write: en %b data %h post_en %b expected %b %h 0",
               wb_en, wb_data, post_en, {e.a, e.d, e.m}, e.data);
    end
    tests_run++;
    if (pc_after !== e.pc_next) begin
      tests_failed++;
      $display("[TB] FAIL a_pc: got %h expected %h", pc_after, e.pc_next);
    end
    model_pc = e.pc_next;
  endtask

  task automatic test_c_dest();
    exp_t e;
    e = model(model_pc, 16'hE098, 16'sh5678, 16'h0100);
    exec_instr(16'hE098, 0, 16'sh5678, 16'h0100);
    tests_run++;
    if (wb_en !== {e.a, e.d, e.m} || wb_data !== e.data) begin
      tests_failed++;
      $display("[TB] FAIL c_dest_dm: en %b data %h expected %b %h",
               wb_en, wb_data, {e.a, e.d, e.m}, e.data);
    end
    tests_run++;
    if (exec_ctrl !== 7'(16'hE098 >> 6) || wb_ctrl !== exec_ctrl) begin
      tests_failed++;
      $display("[TB] FAIL c_alu_ctrl: exec %h wb %h expected %h",
               exec_ctrl, wb_ctrl, 7'(16'hE098 >> 6));
    end
    tests_run++;
    if (post_data !== e.data || post_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL c_hold: data %h en %b expected %h 0", post_data, post_en, e.data);
    end
    model_pc = e.pc_next;
  endtask

  task automatic test_jump();
    exp_t e;
    e = model(model_pc, 16'hE304, -16'sd5, 16'h0040);
    exec_instr(16'hE304, 1, -16'sd5, 16'h0040);
    tests_run++;
    if (pc_after !== e.pc_next || pc_after !== 16'h0040) begin
      tests_failed++;
      $display("[TB] FAIL jlt_taken: pc got %h expected %h", pc_after, e.pc_next);
    end
    model_pc = e.pc_next;
    e = model(model_pc, 16'hE304, 16'sd3, 16'h0040);
    exec_instr(16'hE304, 0, 16'sd3, 16'h0040);
    tests_run++;
    if (pc_after !== e.pc_next) begin
      tests_failed++;
      $display("[TB] FAIL jlt_not_taken: pc got %h expected %h", pc_after, e.pc_next);
    end
    model_pc = e.pc_next;
  endtask

  task automatic test_pc_wrap();
    exp_t e;
    e = model(model_pc, 16'hEA87, 16'sd0, 16'hFFFF);
    exec_instr(16'hEA87, 0, 16'sd0, 16'hFFFF);
    tests_run++;
    if (pc_after !== e.pc_next) begin
      tests_failed++;
      $display("[TB] FAIL jmp_to_ffff: pc got %h expected %h", pc_after, e.pc_next);
    end
    model_pc = e.pc_next;
    e = model(model_pc, 16'h0ABC, 16'sd0, 16'h0);
    exec_instr(16'h0ABC, 0, 16'sd9, 16'h0);
    tests_run++;
    if (pc_after !== e.pc_next || pc_after !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL pc_wrap: pc got %h expected %h", pc_after, e.pc_next);
    end
    model_pc = e.pc_next;
  endtask

  task automatic test_fetch_stall();
    exp_t e;
    e = model(model_pc, 16'h0321, 16'sd0, 16'h0);
    exec_instr(16'h0321, 5, 16'sd0, 16'h0);
    tests_run++;
    if (stall_ok !== 1'b1 || start_req !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL fetch_stall: stable %b req %b expected 1 1", stall_ok, start_req);
    end
    tests_run++;
    if (pc_after !== e.pc_next || wb_data !== e.data) begin
      tests_failed++;
      $display("[TB] FAIL stall_exec: pc %h data %h expected %h %h",
               pc_after, wb_data, e.pc_next, e.data);
    end
    model_pc = e.pc_next;
  endtask

  task automatic test_random();
    exp_t e;
    logic [15:0] instr, a;
    logic signed [15:0] r;
    int stall;
    for (int n = 0; n < 40; n++) begin
      instr = 16'($urandom);
      if ($urandom_range(0, 1) == 0) instr[15:13] = 3'b111;
      r = 16'($urandom);
      if ($urandom_range(0, 3) == 0) r = 16'sd0;
      a = 16'($urandom);
      if (instr[15] && instr[2:0] == 3'b111 && a == model_pc) a = a + 16'd1;
      stall = $urandom_range(0, 3);
      e = model(model_pc, instr, r, a);
      exec_instr(instr, stall, r, a);
      tests_run++;
      if (stall_ok !== 1'b1 || {start_req, exec_req, exec_en, post_req} !== 4'b1001) begin
        tests_failed++;
        $display("[TB] FAIL rand_seq[%0d]: stall %b req/exec_req/exec_en/next %b expected 1 1001",
                 n, stall_ok, {start_req, exec_req, exec_en, post_req});
      end
      tests_run++;
      if (exec_ctrl !== instr[12:6] || wb_ctrl !== instr[12:6]) begin
        tests_failed++;
        $display("[TB] FAIL rand_ctrl[%0d]: exec %h wb %h expected %h", n, exec_ctrl, wb_ctrl, instr[12:6]);
      end
      tests_run++;
      if (wb_en !== {e.a, e.d, e.m} || wb_data !== e.data || wb_pc !== model_pc) begin
        tests_failed++;
        $display("[TB] FAIL rand_wb[%0d]: en %b data %h pc %h expected %b %h %h",
                 n, wb_en, wb_data, wb_pc, {e.a, e.d, e.m}, e.data, model_pc);
      end
      tests_run++;
      if (post_en !== 1'b0 || post_data !== e.data || {wb_halted, post_halted} !== 2'b00) begin
        tests_failed++;
        $display("[TB] FAIL rand_post[%0d]: en %b data %h halted %b expected 0 %h 00",
                 n, post_en, post_data, {wb_halted, post_halted}, e.data);
      end
      tests_run++;
      if (pc_after !== e.pc_next) begin
        tests_failed++;
        $display("[TB] FAIL rand_pc[%0d]: got %h expected %h", n, pc_after, e.pc_next);
      end
      model_pc = e.pc_next;
    end
  endtask

  task automatic test_reset_mid_wb();
    logic [2:0] en_before;
    alu_out = 16'h4321; alu_zr = 1'b0; alu_ng = 1'b0; a_in = 16'h2222;
    instr_in = 16'hEC38; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(posedge clk); #1;
    en_before = {reg_a_en, reg_d_en, reg_m_en};
    rst = 1'b1; #1;
    tests_run++;
    if (en_before !== 3'b111) begin
      tests_failed++;
      $display("[TB] FAIL mid_wb_entry: en got %b expected 111", en_before);
    end
    tests_run++;
    if (any_en !== 1'b0 || pc_out !== PC_RESET || data_out !== 16'h0 || instr_req !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL mid_wb_reset: en %b pc %h data %h req %b expected 0 %h 0000 0",
               any_en, pc_out, data_out, instr_req, PC_RESET);
    end
    @(posedge clk); #1;
    tests_run++;
    if (any_en !== 1'b0 || pc_out !== PC_RESET) begin
      tests_failed++;
      $display("[TB] FAIL mid_wb_hold: en %b pc %h expected 0 %h", any_en, pc_out, PC_RESET);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (instr_req !== 1'b1 || pc_out !== PC_RESET) begin
      tests_failed++;
      $display("[TB] FAIL mid_wb_restart: req %b pc %h expected 1 %h", instr_req, pc_out, PC_RESET);
    end
    model_pc = PC_RESET;
  endtask

  task automatic test_self_jump();
    exp_t e;
    logic [15:0] here;
    exec_instr(16'h0077, 0, 16'sd0, 16'h0);
    model_pc = 16'((int'(model_pc) + 1) % 65536);
    here = model_pc;
    e = model(here, 16'hEA87, 16'sd0, here);
    exec_instr(16'hEA87, 0, 16'sd0, here);
    tests_run++;
    if (pc_after !== e.pc_next || pc_after !== here) begin
      tests_failed++;
      $display("[TB] FAIL self_jump_pc: got %h expected %h", pc_after, here);
    end
    tests_run++;
    if (wb_halted !== e.halt || post_halted !== e.halt || post_req !== !e.halt) begin
      tests_failed++;
      $display("[TB] FAIL self_jump_state: halted %b/%b req %b expected %b/%b %b",
               wb_halted, post_halted, post_req, e.halt, e.halt, !e.halt);
    end
    if (e.halt) begin
      logic stuck_ok;
      stuck_ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
        if (instr_req !== 1'b0 || any_en !== 1'b0 || halted !== 1'b1 || pc_out !== here) stuck_ok = 1'b0;
        @(negedge clk);
      end
      tests_run++;
      if (stuck_ok !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL halt_hold: stayed halted %b expected 1", stuck_ok);
      end
    end else begin
      exec_instr(16'hEA87, 0, 16'sd0, here);
      tests_run++;
      if (pc_after !== here || start_req !== 1'b1 || post_req !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL self_loop_repeat: pc %h req %b/%b expected %h 1/1",
                 pc_after, start_req, post_req, here);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_a_instr();
    test_c_dest();
    test_jump();
    test_pc_wrap();
    test_fetch_stall();
    test_random();
    test_reset_mid_wb();
    test_self_jump();
    test_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
